gcd_rr_arbiter: RTL and testbench
=================================

// Module: gcd_rr_arbiter
// PURPOSE
//  Shares one HostGcdUnit (val/rdy: 32b req, 16b resp) between p_num_reqs requester ports.
//  - Round-robin arbitration; one transaction outstanding at a time (the GCD unit carries no tag).
//  - Each response returns to the requester that issued the request.
//  - Sits between requester-side test sources/sinks or host shims and a single GCD unit.
// PARAMETERS
//  p_num_reqs    4   number of requester ports (2..8)
//  p_opnd_nbits  16  operand/result width; req msg = 2*p_opnd_nbits = {opnd_a, opnd_b}
// PORTS
//  clk           in   1        clock, all state on posedge
//  reset_n       in   1        asynchronous, active-low reset
//  in_req_val    in   N        per-requester request valid
//  in_req_rdy    out  N        per-requester request ready
//  in_req_msg    in   N*32     requester i occupies bits [32*i+31:32*i]
//  out_resp_val  out  N        per-requester response valid
//  out_resp_rdy  in   N        per-requester response ready
//  out_resp_msg  out  N*16     requester i occupies bits [16*i+15:16*i]
//  gcd_req_val   out  1        request valid to GCD unit
//  gcd_req_rdy   in   1        request ready from GCD unit
//  gcd_req_msg   out  32       request msg to GCD unit
//  gcd_resp_val  in   1        response valid from GCD unit
//  gcd_resp_rdy  out  1        response ready to GCD unit
//  gcd_resp_msg  in   16       response msg from GCD unit
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, ptr=0, grant=0.
//    All val/rdy outputs 0; gcd_req_msg and out_resp_msg driven 0.
//  - Fire on any interface = val && rdy in the same cycle.
//  - Requesters hold val and msg stable until fire (standard val/rdy contract).
//  - FSM states:
//    - IDLE: if |in_req_val, grant <= first valid index searching ptr, ptr+1, ... (mod N);
//      go REQ. Else stay IDLE. All handshake outputs are 0 in IDLE.
//    - REQ: gcd_req_val=1, gcd_req_msg=in_req_msg[grant], in_req_rdy[grant]=gcd_req_rdy,
//      all other in_req_rdy=0. On fire, go BUSY. Grant is locked in REQ;
//      a newly valid higher-priority requester does not preempt it.
//    - BUSY: out_resp_val[grant]=gcd_resp_val, out_resp_msg[grant]=gcd_resp_msg,
//      gcd_resp_rdy=out_resp_rdy[grant]. Other out_resp_val=0; other out_resp_msg=0.
//      On fire: ptr <= (grant+1) mod N, go IDLE.
//  - Combinational paths: the rdy/val pass-throughs in REQ and BUSY only; no added buffering.
//  - Latency (macro off): 1 arbitration cycle (IDLE) before each request is presented.
//    Throughput is at most one transaction per (GCD latency + 2) cycles.
//  - Fairness: ptr advances only on response fire; a continuously valid requester waits
//    at most N-1 transactions.
//  - Boundary cases:
//    - A single valid requester is granted repeatedly with no starvation penalty.
//    - ptr wraps from N-1 to 0.
//    - gcd_resp_val is ignored outside BUSY and must never arrive there.
//    - A reset asserted mid-transaction drops the transaction with no response;
//      the GCD unit is reset in the same domain.
// CONFIGURATION
//  GCD_ARB_B2B_EN
//  - Defined: on response fire in BUSY, arbitrate in the same cycle using the updated ptr.
//    If any in_req_val is set (the current grantee's val is also sampled), load grant and
//    go directly to REQ; otherwise go to IDLE. Removes the idle cycle between transactions.
//  - Undefined: BUSY always returns to IDLE, per the FSM above.
// TESTING
//  - Single port: port 0 sends {16'd15,16'd5}, then 100 more transactions
//    -> port 0 receives 5 each time; other ports see no val.
//  - Contention: all 4 ports hold {27,9},{48,18},{7,13},{100,75} from cycle 0
//    -> grant order 0,1,2,3; results 9,6,1,25; ptr=0 after the 4th response.
//  - Fairness/wrap: ports 1 and 3 hold a continuous stream
//    -> grants strictly alternate 1,3,1,3 over 20 transactions.
//  - Backpressure: port 2 out_resp_rdy=0 for 10 cycles
//    -> gcd_resp_rdy=0, response held stable, no new gcd_req_val until drained.
//    Repeat with random src/sink delay 0..7 and 1000 msgs per port; every result matches golden.
//  - Reset mid-op: deassert reset_n while in BUSY
//    -> all outputs 0 immediately; first grant after release goes to port 0.
//  - GCD_ARB_B2B_EN defined: 4 continuously valid ports
//    -> gcd_req_val rises the cycle after each response fire (no IDLE cycle).
//    Same streams give identical results with the macro off or on.

Source files
------------

// File: rtl/gcd_rr_arbiter_if.sv
// gcd_rr_arbiter_if: requester-side and GCD-side val/rdy bundles.
// slave = arbiter view, master = environment view.
interface gcd_rr_arbiter_if #(
    parameter int p_num_reqs   = 4,
    parameter int p_opnd_nbits = 16
);
    localparam int N  = p_num_reqs;
    localparam int W  = p_opnd_nbits;
    localparam int RW = 2 * p_opnd_nbits;

    logic [N-1:0]    in_req_val;
    logic [N-1:0]    in_req_rdy;
    logic [N*RW-1:0] in_req_msg;
    logic [N-1:0]    out_resp_val;
    logic [N-1:0]    out_resp_rdy;
    logic [N*W-1:0]  out_resp_msg;
    logic            gcd_req_val;
    logic            gcd_req_rdy;
    logic [RW-1:0]   gcd_req_msg;
    logic            gcd_resp_val;
    logic            gcd_resp_rdy;
    logic [W-1:0]    gcd_resp_msg;

    modport slave (
        input  in_req_val, in_req_msg, out_resp_rdy,
        input  gcd_req_rdy, gcd_resp_val, gcd_resp_msg,
        output in_req_rdy, out_resp_val, out_resp_msg,
        output gcd_req_val, gcd_req_msg, gcd_resp_rdy
    );

    modport master (
        output in_req_val, in_req_msg, out_resp_rdy,
        output gcd_req_rdy, gcd_resp_val, gcd_resp_msg,
        input  in_req_rdy, out_resp_val, out_resp_msg,
        input  gcd_req_val, gcd_req_msg, gcd_resp_rdy
    );
endinterface

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: round-robin share of one untagged GCD unit, one transaction in flight.
// Define GCD_ARB_B2B_EN to re-arbitrate on response fire and skip the IDLE cycle.
module gcd_rr_arbiter #(
    parameter int p_num_reqs   = 4,
    parameter int p_opnd_nbits = 16
) (
    input logic               clk,
    input logic               reset_n,
    gcd_rr_arbiter_if.slave   bus
);
    localparam int N  = p_num_reqs;
    localparam int W  = p_opnd_nbits;
    localparam int RW = 2 * p_opnd_nbits;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_nxt;

    // First valid requester at or after base, wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(
        input logic [IW-1:0] base,
        input logic [N-1:0]  val
    );
        logic [IW-1:0] sel;
        logic          hit;
        int            idx;
        sel = base;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(base) + k) % N;
            if (!hit && val[idx]) begin
                sel = IW'(idx);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    assign ptr_nxt = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);

    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        grant_d           = grant_q;
        bus.in_req_rdy    = '0;
        bus.out_resp_val  = '0;
        bus.out_resp_msg  = '0;
        bus.gcd_req_val   = 1'b0;
        bus.gcd_req_msg   = '0;
        bus.gcd_resp_rdy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|bus.in_req_val) begin
                    grant_d = rr_pick(ptr_q, bus.in_req_val);
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.gcd_req_val         = 1'b1;
                bus.gcd_req_msg         = bus.in_req_msg[int'(grant_q)*RW +: RW];
                bus.in_req_rdy[grant_q] = bus.gcd_req_rdy;
                if (bus.gcd_req_rdy) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.out_resp_val[grant_q]               = bus.gcd_resp_val;
                bus.out_resp_msg[int'(grant_q)*W +: W]  = bus.gcd_resp_msg;
                bus.gcd_resp_rdy                        = bus.out_resp_rdy[grant_q];
                if (bus.gcd_resp_val && bus.out_resp_rdy[grant_q]) begin
                    ptr_d = ptr_nxt;
`ifdef GCD_ARB_B2B_EN
                    if (|bus.in_req_val) begin
                        grant_d = rr_pick(ptr_nxt, bus.in_req_val);
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_gcd_rr_arbiter.sv
// tb_gcd_rr_arbiter: directed and randomised streams through gcd_rr_arbiter
// with a small behavioural GCD unit; expected results are hand constants or Euclid.
module tb_gcd_rr_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gcd_rr_arbiter_if #(.p_num_reqs(N), .p_opnd_nbits(16)) bus ();

    gcd_rr_arbiter #(.p_num_reqs(N), .p_opnd_nbits(16)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] gcd16(input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural GCD unit: fixed two-cycle compute, then holds the result.
    logic        g_busy;
    logic [1:0]  g_cnt;
    logic [15:0] g_res;
    assign bus.gcd_req_rdy  = ~g_busy;
    assign bus.gcd_resp_val = g_busy && (g_cnt == 2'd0);
    assign bus.gcd_resp_msg = g_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_busy <= 1'b0;
            g_cnt  <= 2'd0;
            g_res  <= 16'd0;
        end else if (!g_busy) begin
            if (bus.gcd_req_val) begin
                g_busy <= 1'b1;
                g_cnt  <= 2'd2;
                g_res  <= gcd16(bus.gcd_req_msg[31:16], bus.gcd_req_msg[15:0]);
            end
        end else if (g_cnt != 2'd0) begin
            g_cnt <= g_cnt - 2'd1;
        end else if (bus.gcd_resp_rdy) begin
            g_busy <= 1'b0;
        end
    end

    logic [15:0] dir_a [N];
    logic [15:0] dir_b [N];
    logic [15:0] dir_e [N];
    logic [15:0] exp_q [N][$];
    int          grant_log[$];
    int          stray;
    int          b2b_n;
    int          b2b_hit;

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.in_req_val   = '0;
        bus.in_req_msg   = '0;
        bus.out_resp_rdy = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Cycle-stepped sources/sinks; entered and left at posedge+1.
    task automatic run_stream(input logic [N-1:0] mask, input int m,
                              input bit rnd);
        int          sent[N], rcv[N], sw[N], kw[N];
        bit          pf[N], rf[N];
        bit          done, any_rf, b2b_pend;
        int          cyc, budget;
        logic [15:0] a, b;
        budget   = m * N * 40 + 200;
        done     = 1'b0;
        b2b_pend = 1'b0;
        grant_log.delete();
        stray   = 0;
        b2b_n   = 0;
        b2b_hit = 0;
        bus.in_req_val   = '0;
        bus.out_resp_rdy = '0;
        for (int p = 0; p < N; p++) begin
            exp_q[p].delete();
            sent[p] = 0;
            rcv[p]  = 0;
            sw[p]   = rnd ? int'($urandom_range(0, 7)) : 0;
            kw[p]   = rnd ? int'($urandom_range(0, 7)) : 0;
            pf[p]   = 1'b0;
            rf[p]   = 1'b0;
        end
        for (cyc = 0; cyc < budget; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (pf[p]) begin
                    bus.in_req_val[p] = 1'b0;
                    sent[p]++;
                    sw[p] = rnd ? int'($urandom_range(0, 7)) : 0;
                end
                if (rf[p]) begin
                    bus.out_resp_rdy[p] = 1'b0;
                    rcv[p]++;
                    kw[p] = rnd ? int'($urandom_range(0, 7)) : 0;
                end
                if (mask[p] && !bus.in_req_val[p] && sent[p] < m) begin
                    if (sw[p] == 0) begin
                        if (rnd) begin
                            a = 16'($urandom_range(1, 1000));
                            b = 16'($urandom_range(1, 1000));
                            exp_q[p].push_back(gcd16(a, b));
                        end else begin
                            a = dir_a[p];
                            b = dir_b[p];
                            exp_q[p].push_back(dir_e[p]);
                        end
                        bus.in_req_msg[32*p +: 32] = {a, b};
                        bus.in_req_val[p] = 1'b1;
                    end else begin
                        sw[p]--;
                    end
                end
                if (mask[p] && !bus.out_resp_rdy[p] && rcv[p] < m) begin
                    if (kw[p] == 0) bus.out_resp_rdy[p] = 1'b1;
                    else kw[p]--;
                end
            end
            done = 1'b1;
            for (int p = 0; p < N; p++)
                if (mask[p] && rcv[p] < m) done = 1'b0;
            if (done) break;
            @(negedge clk);
            if (b2b_pend) begin
                b2b_n++;
                if (bus.gcd_req_val) b2b_hit++;
            end
            any_rf = 1'b0;
            for (int p = 0; p < N; p++) begin
                pf[p] = bus.in_req_val[p] && bus.in_req_rdy[p];
                rf[p] = bus.out_resp_val[p] && bus.out_resp_rdy[p];
                if (pf[p]) grant_log.push_back(p);
                if (!mask[p] && (bus.out_resp_val[p] || bus.in_req_rdy[p]))
                    stray++;
                if (rf[p]) begin
                    any_rf = 1'b1;
                    if (exp_q[p].size() == 0)
                        chk($sformatf("spurious_resp%0d", p), 32'd1, 32'd0);
                    else
                        chk($sformatf("resp%0d", p),
                            32'(bus.out_resp_msg[16*p +: 16]),
                            32'(exp_q[p].pop_front()));
                end
            end
            b2b_pend = any_rf && (|bus.in_req_val);
            @(posedge clk);
            #1;
        end
        chk("stream_done", 32'(done), 32'd1);
        chk("stream_stray", 32'(stray), 32'd0);
        bus.out_resp_rdy = '0;
    endtask

    initial begin
        bit ok;
        int nz;

        rst_n            = 1'b0;
        bus.in_req_val   = '0;
        bus.in_req_msg   = '0;
        bus.out_resp_rdy = '0;
        dir_a = '{16'd27, 16'd48, 16'd7,  16'd100};
        dir_b = '{16'd9,  16'd18, 16'd13, 16'd75};
        dir_e = '{16'd9,  16'd6,  16'd1,  16'd25};

        // reset state, with requests pending to show they are not acted on
        bus.in_req_val = '1;
        @(negedge clk);
        chk("rst_gcd_req_val", 32'(bus.gcd_req_val), 32'd0);
        chk("rst_gcd_req_msg", 32'(bus.gcd_req_msg), 32'd0);
        chk("rst_in_req_rdy", 32'(bus.in_req_rdy), 32'd0);
        chk("rst_out_resp_val", 32'(bus.out_resp_val), 32'd0);
        chk("rst_out_resp_msg", 32'(bus.out_resp_msg), 32'd0);
        chk("rst_gcd_resp_rdy", 32'(bus.gcd_resp_rdy), 32'd0);
        do_reset();

        // single port, 101 transactions of {15,5}
        dir_a[0] = 16'd15;
        dir_b[0] = 16'd5;
        dir_e[0] = 16'd5;
        run_stream(4'b0001, 101, 1'b0);
        chk("single_grants", 32'(grant_log.size()), 32'd101);
        nz = 0;
        foreach (grant_log[i]) if (grant_log[i] != 0) nz++;
        chk("single_other_port", 32'(nz), 32'd0);
        dir_a[0] = 16'd27;
        dir_b[0] = 16'd9;
        dir_e[0] = 16'd9;

        // contention from reset: order 0,1,2,3, then ptr back at 0
        do_reset();
        run_stream(4'b1111, 1, 1'b0);
        chk("cont_grants", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("cont_grant%0d", i), 32'(grant_log[i]), 32'(i));
        run_stream(4'b1010, 1, 1'b0);
        chk("cont_ptr_wrapped", 32'(grant_log[0]), 32'd1);

        // fairness: ports 1 and 3 continuously valid
        do_reset();
        run_stream(4'b1010, 10, 1'b0);
        chk("fair_grants", 32'(grant_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < grant_log.size(); i++)
            chk($sformatf("fair_grant%0d", i), 32'(grant_log[i]),
                (i % 2 == 0) ? 32'd1 : 32'd3);

        // backpressure on port 2 while port 0 waits
        do_reset();
        bus.in_req_msg[64 +: 32] = {16'd27, 16'd9};
        bus.in_req_val[2] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_req_val[2] && bus.in_req_rdy[2];
        end
        chk("bp_req_fire", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.in_req_val[2] = 1'b0;
        bus.in_req_msg[0 +: 32] = {16'd48, 16'd18};
        bus.in_req_val[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_resp_val[2];
        end
        chk("bp_resp_val", 32'(ok), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_gcd_resp_rdy", 32'(bus.gcd_resp_rdy), 32'd0);
            chk("bp_hold_msg", 32'(bus.out_resp_msg[47:32]), 32'd9);
            chk("bp_no_new_req", 32'(bus.gcd_req_val), 32'd0);
            @(negedge clk);
        end
        bus.out_resp_rdy[2] = 1'b1;
        #1;
        chk("bp_drain_rdy", 32'(bus.gcd_resp_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.out_resp_rdy[2] = 1'b0;
        bus.out_resp_rdy[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_resp_val[0] && bus.out_resp_rdy[0];
        end
        chk("bp_next_resp", 32'(ok), 32'd1);
        chk("bp_next_msg", 32'(bus.out_resp_msg[15:0]), 32'd6);
        @(posedge clk);
        #1;
        bus.in_req_val[0]   = 1'b0;
        bus.out_resp_rdy[0] = 1'b0;

        // reset while BUSY: ptr at 3 beforehand, first grant after is 0
        do_reset();
        run_stream(4'b0100, 1, 1'b0);
        bus.in_req_msg[32 +: 32] = {16'd48, 16'd18};
        bus.in_req_val[1] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_req_val[1] && bus.in_req_rdy[1];
        end
        chk("rm_req_fire", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        bus.in_req_val[1] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_resp_val[1];
        end
        chk("rm_busy", 32'(ok), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rm_gcd_req_val", 32'(bus.gcd_req_val), 32'd0);
        chk("rm_gcd_resp_rdy", 32'(bus.gcd_resp_rdy), 32'd0);
        chk("rm_out_resp_val", 32'(bus.out_resp_val), 32'd0);
        chk("rm_out_resp_msg", 32'(bus.out_resp_msg), 32'd0);
        chk("rm_in_req_rdy", 32'(bus.in_req_rdy), 32'd0);
        do_reset();
        run_stream(4'b1001, 1, 1'b0);
        chk("rm_first_grant", 32'(grant_log[0]), 32'd0);

        // back-to-back behaviour with all four ports streaming
        do_reset();
        run_stream(4'b1111, 5, 1'b0);
        chk("b2b_samples", 32'(b2b_n > 0), 32'd1);
`ifdef GCD_ARB_B2B_EN
        chk("b2b_back_to_back", 32'(b2b_hit), 32'(b2b_n));
`else
        chk("b2b_idle_gap", 32'(b2b_hit), 32'd0);
`endif

        // random src/sink delays, 1000 messages per port
        do_reset();
        run_stream(4'b1111, 1000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
